// File: rtl/parallax_pkg.sv
// Shared definitions for the parallax scroll scheduler: CTRL layout, sweep
// states and small helpers used by the register file and the sweep engine.
package parallax_pkg;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_CLR_OFS_BIT = 1;
   localparam int CTRL_CLR_OVR_BIT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sweep_state_e;

   // CTRL sits directly after the per-layer speed registers.
   function automatic int ctrl_addr(input int layers);
      return layers;
   endfunction

   function automatic logic [31:0] sext(input logic [31:0] v, input int w);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF << w;
      if (((v >> (w - 1)) & 32'd1) != 32'd0) return v | mask;
      return v & ~mask;
   endfunction

endpackage

// File: rtl/parallax_cfg_regs.sv
// Configuration register file: per-layer speeds, CTRL enable, write-1 clear
// pulses and registered readback.
module parallax_cfg_regs
   import parallax_pkg::*;
#(
   parameter int LAYERS = 4,
   parameter int SPD_W  = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [15:0]       wdata_i,
   input  logic              overrun_i,
   output logic [SPD_W-1:0]  speed_o [LAYERS],
   output logic              enable_o,
   output logic              clr_ofs_o,
   output logic              clr_ovr_o,
   output logic [15:0]       rdata_o
);

   localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_addr(LAYERS));

   logic [SPD_W-1:0] spd_q [LAYERS];
   logic             en_q;
   logic [15:0]      rdata_q;
   logic [15:0]      rdata_d;
   logic [31:0]      spd_sx;
   logic             ctrl_wr;
   logic             unused_bits;

   assign ctrl_wr   = we_i && (addr_i == CTRL_ADDR);
   assign clr_ofs_o = ctrl_wr && wdata_i[CTRL_CLR_OFS_BIT];
   assign clr_ovr_o = ctrl_wr && wdata_i[CTRL_CLR_OVR_BIT];

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      rdata_d = '0;
      spd_sx  = '0;
      for (int i = 0; i < LAYERS; i++) begin
         if (addr_i == ADDR_W'(i)) begin
            spd_sx  = sext(32'(spd_q[i]), SPD_W);
            rdata_d = spd_sx[15:0];
         end
      end
      if (addr_i == CTRL_ADDR) begin
         rdata_d[CTRL_EN_BIT]      = en_q;
         rdata_d[CTRL_CLR_OVR_BIT] = overrun_i;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (reset) begin
         // NOTE: the speed array is small and must read back as zero, so it is reset like plain flops.
         for (int i = 0; i < LAYERS; i++) spd_q[i] <= '0;
         en_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         for (int i = 0; i < LAYERS; i++) begin
            if (we_i && (addr_i == ADDR_W'(i))) spd_q[i] <= wdata_i[SPD_W-1:0];
         end
         if (ctrl_wr) en_q <= wdata_i[CTRL_EN_BIT];
         if (re_i) rdata_q <= rdata_d;
      end
   end

   assign speed_o     = spd_q;
   assign enable_o    = en_q;
   assign rdata_o     = rdata_q;
   assign unused_bits = ^{wdata_i, spd_sx};

endmodule

// File: rtl/parallax_scroll_sched.sv
// Per-frame parallax scroll scheduler: on an accepted frame start, walks the
// layers one per cycle and adds each layer's signed speed to its offset.
module parallax_scroll_sched
   import parallax_pkg::*;
#(
   parameter int LAYERS  = 4,
   parameter int OFS_W   = 10,
   parameter int SPD_W   = 4,
   parameter int FRAME_W = 16,
   parameter int ADDR_W  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      frame_start,
   input  logic                      cfg_we,
   input  logic                      cfg_re,
   input  logic [ADDR_W-1:0]         cfg_addr,
   input  logic [15:0]               cfg_wdata,
   output logic [15:0]               cfg_rdata,
   output logic [LAYERS*OFS_W-1:0]   layer_offset,
   output logic [FRAME_W-1:0]        frame_count,
   output logic                      busy,
   output logic                      update_done,
   output logic                      overrun
);

   localparam int                 IDX_W    = $clog2(LAYERS);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(LAYERS - 1);

   if (LAYERS < 2 || LAYERS > 15 || LAYERS + 1 > (1 << ADDR_W)) begin : g_bad_params
      $error("parallax_scroll_sched: LAYERS must be 2..15 and fit below the CTRL address");
   end

   sweep_state_e       state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [OFS_W-1:0]   ofs_q [LAYERS];
   logic [FRAME_W-1:0] fc_q;
   logic               ovr_q;
   logic [SPD_W-1:0]   speed [LAYERS];
   logic [SPD_W-1:0]   spd_cur;
   logic [31:0]        inc_full;
   logic               enable, clr_ofs, clr_ovr, start;
   logic               unused_bits;

   parallax_cfg_regs #(
      .LAYERS (LAYERS),
      .SPD_W  (SPD_W),
      .ADDR_W (ADDR_W)
   ) u_cfg (
      .clk       (clk),
      .reset     (reset),
      .we_i      (cfg_we),
      .re_i      (cfg_re),
      .addr_i    (cfg_addr),
      .wdata_i   (cfg_wdata),
      .overrun_i (ovr_q),
      .speed_o   (speed),
      .enable_o  (enable),
      .clr_ofs_o (clr_ofs),
      .clr_ovr_o (clr_ovr),
      .rdata_o   (cfg_rdata)
   );

   // A clear in the same cycle as a frame start wins: no sweep is launched.
   assign start = (state_q == IDLE) && frame_start && enable && !clr_ofs;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = SWEEP;
         SWEEP: begin
            if (clr_ofs)                  state_d = IDLE;
            else if (idx_q == LAST_IDX)   state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q == SWEEP);
      update_done = (state_q == DONE) && !clr_ofs;
   end

   always_comb begin
      spd_cur = '0;
      for (int i = 0; i < LAYERS; i++) begin
         if (idx_q == IDX_W'(i)) spd_cur = speed[i];
      end
   end

   assign inc_full = sext(32'(spd_cur), SPD_W);

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= '0;
         fc_q  <= '0;
         ovr_q <= 1'b0;
         for (int i = 0; i < LAYERS; i++) ofs_q[i] <= '0;
      end else begin
         idx_q <= (state_q == SWEEP) ? idx_q + 1'b1 : '0;
         if (start) fc_q <= fc_q + 1'b1;
         // Set beats clear when both land in the same cycle.
         if (busy && frame_start) ovr_q <= 1'b1;
         else if (clr_ovr)        ovr_q <= 1'b0;
         for (int i = 0; i < LAYERS; i++) begin
            if (clr_ofs)                          ofs_q[i] <= '0;
            else if (busy && idx_q == IDX_W'(i))  ofs_q[i] <= ofs_q[i] + inc_full[OFS_W-1:0];
         end
      end
   end

   for (genvar g = 0; g < LAYERS; g++) begin : g_ofs_bus
      assign layer_offset[g*OFS_W +: OFS_W] = ofs_q[g];
   end

   assign frame_count = fc_q;
   assign overrun     = ovr_q;
   assign unused_bits = ^inc_full;

endmodule

// File: tb/tb_parallax_scroll_sched.sv
// Self-checking bench for parallax_scroll_sched: directed scenarios plus
// randomized traffic against a timestamp-based reference model.
module tb_parallax_scroll_sched;

   localparam int LAYERS  = 4;
   localparam int OFS_W   = 10;
   localparam int SPD_W   = 4;
   localparam int FRAME_W = 16;
   localparam int ADDR_W  = 4;
   localparam int CTRL    = LAYERS;

   logic                    clk = 1'b0;
   logic                    reset, frame_start, cfg_we, cfg_re;
   logic [ADDR_W-1:0]       cfg_addr;
   logic [15:0]             cfg_wdata, cfg_rdata;
   logic [LAYERS*OFS_W-1:0] layer_offset;
   logic [FRAME_W-1:0]      frame_count;
   logic                    busy, update_done, overrun;

   always #5 clk = ~clk;

   parallax_scroll_sched #(
      .LAYERS(LAYERS), .OFS_W(OFS_W), .SPD_W(SPD_W), .FRAME_W(FRAME_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_start  (frame_start),
      .cfg_we       (cfg_we),
      .cfg_re       (cfg_re),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .cfg_rdata    (cfg_rdata),
      .layer_offset (layer_offset),
      .frame_count  (frame_count),
      .busy         (busy),
      .update_done  (update_done),
      .overrun      (overrun)
   );

   // Reference model: a sweep is a time window starting at cycle m_t0.
   int m_ofs [LAYERS];
   int m_spd [LAYERS];
   bit m_en, m_ovr, m_act;
   int m_fc, m_rdata, m_t0, cyc;
   bit chk_on;
   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % (1 << OFS_W)) + (1 << OFS_W)) % (1 << OFS_W);
   endfunction

   function automatic bit m_busy();
      return m_act && cyc >= m_t0 && cyc < m_t0 + LAYERS;
   endfunction

   function automatic bit m_done();
      return m_act && cyc == m_t0 + LAYERS;
   endfunction

   function automatic logic [63:0] ofs_bus();
      logic [63:0] r = '0;
      for (int i = 0; i < LAYERS; i++) r |= 64'(m_ofs[i]) << (i * OFS_W);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LAYERS; i++) begin
         m_ofs[i] = 0;
         m_spd[i] = 0;
      end
      m_en = 0; m_ovr = 0; m_act = 0; m_fc = 0; m_rdata = 0; m_t0 = 0;
   endtask

   task automatic model_edge(input bit rst, input bit fs, input bit we, input bit re,
                             input logic [3:0] addr, input logic [15:0] wd);
      int a, layer, v;
      bit b, idle, clr_o, clr_v, en_old, ovr_old;
      if (rst) begin
         model_reset();
         cyc++;
         return;
      end
      a       = int'(addr);
      b       = m_busy();
      idle    = !b && !m_done();
      clr_o   = we && a == CTRL && wd[1];
      clr_v   = we && a == CTRL && wd[2];
      en_old  = m_en;
      ovr_old = m_ovr;
      if (re) begin
         if (a < LAYERS)     m_rdata = m_spd[a] & 16'hFFFF;
         else if (a == CTRL) m_rdata = ovr_old * 4 + en_old;
         else                m_rdata = 0;
      end
      if (clr_o) begin
         for (int i = 0; i < LAYERS; i++) m_ofs[i] = 0;
      end else if (b) begin
         layer = cyc - m_t0;
         m_ofs[layer] = wrap(m_ofs[layer] + m_spd[layer]);
      end
      if (b && fs)  m_ovr = 1;
      else if (clr_v) m_ovr = 0;
      if (we && a < LAYERS) begin
         v = int'(wd[SPD_W-1:0]);
         if (v >= (1 << (SPD_W - 1))) v -= (1 << SPD_W);
         m_spd[a] = v;
      end
      if (we && a == CTRL) m_en = wd[0];
      if (clr_o) m_act = 0;
      if (idle && fs && en_old && !clr_o) begin
         m_act = 1;
         m_t0  = cyc + 1;
         m_fc  = (m_fc + 1) % (1 << FRAME_W);
      end
      cyc++;
   endtask

   task automatic compare_all(input bit clr_now);
      check("busy", busy, m_busy());
      check("update_done", update_done, m_done() && !clr_now);
      check("offsets", layer_offset, ofs_bus());
      check("frame_count", frame_count, m_fc);
      check("overrun", overrun, m_ovr);
      check("rdata", cfg_rdata, m_rdata);
   endtask

   // One clock: drive at the falling edge, compare mid-cycle, model the rising edge.
   task automatic tick(input bit rst, input bit fs, input bit we, input bit re,
                       input logic [3:0] addr, input logic [15:0] wd);
      reset = rst; frame_start = fs; cfg_we = we; cfg_re = re; cfg_addr = addr; cfg_wdata = wd;
      #1;
      if (chk_on) compare_all(we && int'(addr) == CTRL && wd[1]);
      @(posedge clk);
      model_edge(rst, fs, we, re, addr, wd);
      #1;
      reset = 0; frame_start = 0; cfg_we = 0; cfg_re = 0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [15:0] d);
      tick(0, 0, 1, 0, addr, d);
   endtask

   task automatic rd(input logic [3:0] addr);
      tick(0, 0, 0, 1, addr, 16'h0);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 4'h0, 16'h0);
   endtask

   task automatic pulse();
      tick(0, 1, 0, 0, 4'h0, 16'h0);
   endtask

   task automatic frame();
      pulse();
      idle_n(LAYERS + 1);
   endtask

   initial begin
      int wexp [3] = '{3, 10, 17};
      logic [15:0] wd;
      logic [3:0]  addr;
      int sel;

      chk_on = 0; cyc = 0;
      reset = 1; frame_start = 0; cfg_we = 0; cfg_re = 0; cfg_addr = '0; cfg_wdata = '0;
      model_reset();
      tick(1, 0, 0, 0, 4'h0, 16'h0);
      tick(1, 0, 0, 0, 4'h0, 16'h0);
      chk_on = 1;

      // Reset state
      check("rst_offsets", layer_offset, 64'd0);
      check("rst_frame_count", frame_count, 64'd0);
      check("rst_busy", busy, 64'd0);
      check("rst_update_done", update_done, 64'd0);
      check("rst_overrun", overrun, 64'd0);
      check("rst_rdata", cfg_rdata, 64'd0);

      // First frame with speeds {1,2,-1,3}
      wr(4'(CTRL), 16'h0001);
      wr(4'd0, 16'h0001); wr(4'd1, 16'h0002); wr(4'd2, 16'h000F); wr(4'd3, 16'h0003);
      pulse();
      for (int k = 1; k <= 5; k++) begin
         check("sweep_busy", busy, 64'(k <= 4));
         check("sweep_update_done", update_done, 64'(k == 5));
         idle_n(1);
      end
      check("frame1_offsets", layer_offset, {10'd3, 10'd1023, 10'd2, 10'd1});
      check("frame1_count", frame_count, 64'd1);

      // Wrap: bring layer 0 to 1020, then advance by 7 three times
      wr(4'(CTRL), 16'h0003);
      wr(4'd1, 16'h0000); wr(4'd2, 16'h0000); wr(4'd3, 16'h0000);
      wr(4'd0, 16'h000C);
      frame();
      check("wrap_start", layer_offset[OFS_W-1:0], 64'd1020);
      wr(4'd0, 16'h0007);
      for (int f = 0; f < 3; f++) begin
         frame();
         check("wrap_seq", layer_offset[OFS_W-1:0], 64'(wexp[f]));
      end

      // Overrun: second frame_start two cycles into a sweep
      pulse();
      idle_n(1);
      pulse();
      check("ovr_set", overrun, 64'd1);
      check("ovr_frame_count", frame_count, 64'd6);
      idle_n(LAYERS);
      check("ovr_sticky", overrun, 64'd1);
      check("ovr_sweep_finished", busy, 64'd0);
      wr(4'(CTRL), 16'h0005);
      check("ovr_cleared", overrun, 64'd0);

      // clear_offsets while layer 2 is being swept
      pulse();
      idle_n(2);
      wr(4'(CTRL), 16'h0003);
      check("clr_offsets", layer_offset, 64'd0);
      check("clr_busy", busy, 64'd0);
      for (int k = 0; k < 6; k++) begin
         check("clr_no_done", update_done, 64'd0);
         idle_n(1);
      end
      check("clr_frame_count", frame_count, 64'd7);

      // Speed write landing on the layer currently being swept
      wr(4'd1, 16'h0002);
      pulse();
      idle_n(1);
      wr(4'd1, 16'h0005);
      idle_n(3);
      check("collide_old_speed", layer_offset[2*OFS_W-1:OFS_W], 64'd2);
      frame();
      check("collide_new_speed", layer_offset[2*OFS_W-1:OFS_W], 64'd7);

      // Disabled scheduler and readback
      tick(1, 0, 0, 0, 4'h0, 16'h0);
      pulse();
      check("dis_busy", busy, 64'd0);
      idle_n(2);
      check("dis_frame_count", frame_count, 64'd0);
      rd(4'(CTRL));
      check("rd_ctrl", cfg_rdata, 64'h0000);
      wr(4'd2, 16'h000F);
      rd(4'd2);
      check("rd_speed_sext", cfg_rdata, 64'hFFFF);
      rd(4'hF);
      check("rd_unmapped", cfg_rdata, 64'h0000);

      // Randomized traffic, including resets and clears mid-sweep
      wr(4'(CTRL), 16'h0001);
      for (int n = 0; n < 3000; n++) begin
         sel  = int'($urandom_range(0, 6));
         addr = (sel == 6) ? 4'hF : 4'(sel);
         wd   = 16'($urandom);
         if (int'(addr) == CTRL) begin
            wd[0] = ($urandom_range(0, 4) != 0);
            wd[1] = ($urandom_range(0, 15) == 0);
            wd[2] = ($urandom_range(0, 3) == 0);
         end
         tick($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, addr, wd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
